// File: rtl/panda_pkg.sv
// Shared constants and types for the Panda core data-bus responder.
package panda_pkg;

    localparam logic [3:0] MMIO_MTIME_LO    = 4'h0;
    localparam logic [3:0] MMIO_MTIME_HI    = 4'h4;
    localparam logic [3:0] MMIO_UART_TXDATA = 4'h8;
    localparam logic [3:0] MMIO_UART_STATUS = 4'hC;

    localparam int unsigned STATUS_FULL_BIT  = 32'd0;
    localparam int unsigned STATUS_EMPTY_BIT = 32'd1;
    localparam int unsigned STATUS_BUSY_BIT  = 32'd2;
    localparam int unsigned STATUS_OVF_BIT   = 32'd3;
    localparam int unsigned STATUS_CNT_LSB   = 32'd4;
    localparam int unsigned STATUS_CNT_MSB   = 32'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/panda_uart_tx.sv
// Buffered 8N1 UART transmitter: small byte FIFO feeding a registered serializer.
module panda_uart_tx
    import panda_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_valid,
    input  logic [7:0]                    push_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy,
    output logic                          uart_tx_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    logic [7:0]     fifo_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    uart_tx_state_e state_r;
    logic [BW-1:0]  baud_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shift_r;
    logic           tx_r;

    logic pop_s;
    logic push_ok_s;
    logic baud_done_s;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
    assign pop_s       = (state_r == IDLE) && (count_r != {CW{1'b0}});
    assign push_ok_s   = push_valid && ((count_r < CW'(FIFO_DEPTH)) || pop_s);
    assign baud_done_s = (baud_r == BW'(CLKS_PER_BIT - 32'd1));

    assign full      = (count_r == CW'(FIFO_DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign busy      = (state_r != IDLE);
    assign uart_tx_o = tx_r;

    // FIFO storage write port.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            fifo_r[wr_ptr_r] <= push_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(32'd1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(32'd1);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CW'(32'd1);
                2'b01:   count_r <= count_r - CW'(32'd1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Serializer FSM; the line value is registered alongside each state change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            baud_r    <= {BW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_r <= {BW{1'b0}};
                    if (pop_s) begin
                        shift_r <= fifo_r[rd_ptr_r];
                        state_r <= START;
                        tx_r    <= 1'b0;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (baud_done_s) begin
                        baud_r    <= {BW{1'b0}};
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                        tx_r      <= shift_r[0];
                    end else begin
                        baud_r <= baud_r + BW'(32'd1);
                    end
                end
                DATA: begin
                    if (baud_done_s) begin
                        baud_r <= {BW{1'b0}};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_r <= baud_r + BW'(32'd1);
                    end
                end
                STOP: begin
                    tx_r <= 1'b1;
                    if (baud_done_s) begin
                        baud_r  <= {BW{1'b0}};
                        state_r <= IDLE;
                    end else begin
                        baud_r <= baud_r + BW'(32'd1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/panda_data_mem.sv
// Data-bus target for the Panda core: byte-writable RAM plus an MMIO window
// with a free-running 64-bit cycle counter and a buffered UART transmitter.
module panda_data_mem
    import panda_pkg::*;
#(
    parameter int unsigned RAM_WORDS    = 4096,
    parameter logic [31:0] MMIO_BASE    = 32'h8000_0000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_we_i,
    output logic [31:0] data_rdata_o,
    output logic        uart_tx_o
);

    localparam int unsigned RAW = $clog2(RAM_WORDS);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    mem_r [RAM_WORDS];
    logic [63:0]    mtime_r;
    logic           ovf_r;

    logic           ram_sel_s;
    logic           mmio_sel_s;
    logic [3:0]     mmio_off_s;
    logic [RAW-1:0] ram_idx_s;
    logic           push_s;
    logic           ovf_clr_s;
    logic           drop_s;
    logic           full_s;
    logic           empty_s;
    logic           busy_s;
    logic [FCW-1:0] count_s;
    logic [31:0]    status_s;
    logic [31:0]    rdata_s;
    logic           unused_addr_s;

    assign unused_addr_s = ^data_addr_i[1:0];

    assign ram_sel_s  = ({2'b00, data_addr_i[31:2]} < 32'(RAM_WORDS));
    assign mmio_sel_s = (data_addr_i[31:4] == MMIO_BASE[31:4]);
    assign mmio_off_s = {data_addr_i[3:2], 2'b00};
    assign ram_idx_s  = data_addr_i[RAW+1:2];

    assign push_s    = mmio_sel_s && (mmio_off_s == MMIO_UART_TXDATA) && data_we_i[0];
    assign ovf_clr_s = mmio_sel_s && (mmio_off_s == MMIO_UART_STATUS) && data_we_i[0]
                       && data_wdata_i[3];
    // Full FIFO only pops when the serializer is idle, so busy means the byte is lost.
    assign drop_s    = push_s && full_s && busy_s;

    panda_uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_uart_tx (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_valid (push_s),
        .push_data  (data_wdata_i[7:0]),
        .full       (full_s),
        .empty      (empty_s),
        .count      (count_s),
        .busy       (busy_s),
        .uart_tx_o  (uart_tx_o)
    );

    // Byte-lane RAM writes; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (ram_sel_s) begin
            for (int i = 0; i < 4; i++) begin
                if (data_we_i[i]) begin
                    mem_r[ram_idx_s][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Free-running cycle counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime_r <= 64'h0;
        end else begin
            mtime_r <= mtime_r + 64'h1;
        end
    end

    // Sticky overflow flag, cleared by software through STATUS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_s                                 = 32'h0;
        status_s[STATUS_FULL_BIT]                = full_s;
        status_s[STATUS_EMPTY_BIT]               = empty_s;
        status_s[STATUS_BUSY_BIT]                = busy_s;
        status_s[STATUS_OVF_BIT]                 = ovf_r;
        status_s[STATUS_CNT_MSB:STATUS_CNT_LSB]  = 4'(count_s);
    end

    // Combinational read mux; unmapped addresses read as zero.
    always_comb begin
        rdata_s = 32'h0;
        if (ram_sel_s) begin
            rdata_s = mem_r[ram_idx_s];
        end else if (mmio_sel_s) begin
            case (mmio_off_s)
                MMIO_MTIME_LO:    rdata_s = mtime_r[31:0];
                MMIO_MTIME_HI:    rdata_s = mtime_r[63:32];
                MMIO_UART_STATUS: rdata_s = status_s;
                default:          rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign data_rdata_o = rdata_s;

endmodule
